// File: rtl/slave_resp_if.sv
// ----------------------------------------------------------------------------
// slave_resp_if
//
// Purpose: single-beat write handshake between the interconnect (master side)
//          and one slave write-responder (slave side).
//
// Signals:
//   valid     master -> slave  write request, held until accepted
//   addr_in   master -> slave  3-bit write address, stable while valid=1
//   value_in  master -> slave  3-bit write data, stable while valid=1
//   ready     slave  -> master registered accept strobe
// ----------------------------------------------------------------------------
interface slave_resp_if;
    logic       valid;
    logic [2:0] addr_in;
    logic [2:0] value_in;
    logic       ready;

    modport master (
        output valid,
        output addr_in,
        output value_in,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr_in,
        input  value_in,
        output ready
    );
endinterface : slave_resp_if

// File: rtl/slave_resp.sv
// ----------------------------------------------------------------------------
// slave_resp
//
// Purpose: write-responder for one slave port of the interconnect. Accepts
//          single-beat writes over a valid/ready handshake into an 8x3
//          register file, with optional programmable wait states.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        slave_resp_if.slave: valid, addr_in, value_in in; ready out
//   wait_cfg   wait states before ready (0-3), sampled in IDLE
//   rd_addr    read-port address
//   rd_data    registered read data of mem[rd_addr] (old value on same-edge write)
//   wr_count   accepted-write counter, saturates at 255
//   last_addr  address of the most recent accepted write
//
// Build option:
//   SLAVE_WAIT_EN  defined   -> wait_cfg honoured, WAIT state and counter built
//                  undefined -> wait_cfg ignored, IDLE goes straight to ACK
// ----------------------------------------------------------------------------
module slave_resp (
    input  logic               clk,
    input  logic               rst_n,
    slave_resp_if.slave        bus,
    input  logic [1:0]         wait_cfg,
    input  logic [2:0]         rd_addr,
    output logic [2:0]         rd_data,
    output logic [7:0]         wr_count,
    output logic [2:0]         last_addr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic       ready_q;
    logic [2:0] mem_q [8];
    logic [2:0] rd_data_q;
    logic [7:0] wr_count_q;
    logic [2:0] last_addr_q;
    logic       handshake;

`ifdef SLAVE_WAIT_EN
    logic [1:0] cnt_q, cnt_d;
`else
    // wait_cfg is part of the fixed port list but has no effect in this build.
    logic unused_wait_cfg;
    assign unused_wait_cfg = ^wait_cfg;
`endif

    // A write is taken on the edge where the master still holds valid in ACK.
    assign handshake = (state_q == S_ACK) && bus.valid;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
`ifdef SLAVE_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.valid) begin
`ifdef SLAVE_WAIT_EN
                    if (wait_cfg == 2'd0) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = wait_cfg;
                    end
`else
                    state_d = S_ACK;
`endif
                end
            end
`ifdef SLAVE_WAIT_EN
            S_WAIT: begin
                if (!bus.valid) begin
                    // Master withdrew the request: abandon without writing.
                    state_d = S_IDLE;
                    cnt_d   = 2'd0;
                end else if (cnt_q == 2'd1) begin
                    state_d = S_ACK;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d   = cnt_q - 2'd1;
                end
            end
`endif
            S_ACK: begin
                state_d = bus.valid ? S_GAP : S_IDLE;
            end
            // One dead cycle swallows the interconnect's registered valid,
            // which is still high for one cycle after the handshake.
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
`ifdef SLAVE_WAIT_EN
            cnt_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            // Registered copy of "entering ACK"; ACK never lasts two cycles,
            // so ready can never be high on consecutive cycles.
            ready_q <= (state_d == S_ACK);
`ifdef SLAVE_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Register file, read port and write bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is built from flops and must read as all
            // zeros after reset, so every entry is cleared here.
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= 3'd0;
            end
            rd_data_q   <= 3'd0;
            wr_count_q  <= 8'd0;
            last_addr_q <= 3'd0;
        end else begin
            // Reads the pre-edge contents, so a same-edge write shows up on
            // rd_data one edge later.
            rd_data_q <= mem_q[rd_addr];
            if (handshake) begin
                mem_q[bus.addr_in] <= bus.value_in;
                last_addr_q        <= bus.addr_in;
                if (wr_count_q != 8'hFF) begin
                    wr_count_q <= wr_count_q + 8'd1;
                end
            end
        end
    end

    assign bus.ready = ready_q;
    assign rd_data   = rd_data_q;
    assign wr_count  = wr_count_q;
    assign last_addr = last_addr_q;

endmodule : slave_resp

// File: tb/tb_slave_resp.sv
// ----------------------------------------------------------------------------
// tb_slave_resp
//
// Self-checking bench for slave_resp. A transaction-level reference model
// (request run-length counting, array memory, saturating counter) predicts
// ready/rd_data/wr_count/last_addr every cycle; a compare process checks them
// on the falling edge. Directed tests add hand-computed literal expectations.
// Works with SLAVE_WAIT_EN defined or undefined.
// ----------------------------------------------------------------------------
module tb_slave_resp;

    logic       clk;
    logic       rst_n;
    logic [1:0] wait_cfg;
    logic [2:0] rd_addr;
    logic [2:0] rd_data;
    logic [7:0] wr_count;
    logic [2:0] last_addr;

    slave_resp_if bus ();

    slave_resp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .wait_cfg  (wait_cfg),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_count  (wr_count),
        .last_addr (last_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for ready at %0t", name, $time);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: counts consecutive edges with valid seen while the
    // responder is listening; ready is promised once that run reaches the
    // effective wait plus one, and the next edge with valid takes the write.
    // ------------------------------------------------------------------------
    int         m_listen = 0;
    int         m_n      = 0;
    bit         m_gap    = 1'b0;
    logic       m_ready  = 1'b0;
    logic [2:0] m_mem [8];
    logic [2:0] m_rd     = 3'd0;
    int         m_count  = 0;
    logic [2:0] m_last   = 3'd0;

    function automatic int eff_wait(input logic [1:0] w);
`ifdef SLAVE_WAIT_EN
        return int'(w);
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_listen = 0;
        m_n      = 0;
        m_gap    = 1'b0;
        m_ready  = 1'b0;
        m_rd     = 3'd0;
        m_count  = 0;
        m_last   = 3'd0;
        for (int i = 0; i < 8; i++) m_mem[i] = 3'd0;
    endtask

    task automatic model_step();
        logic [2:0] rd_next;
        logic       ready_next;
        rd_next    = m_mem[rd_addr];
        ready_next = 1'b0;
        if (m_gap) begin
            m_gap    = 1'b0;
            m_listen = 0;
        end else if (m_ready) begin
            if (bus.valid) begin
                m_mem[bus.addr_in] = bus.value_in;
                m_last             = bus.addr_in;
                if (m_count < 255) m_count++;
                m_gap = 1'b1;
            end
            m_listen = 0;
        end else if (bus.valid) begin
            if (m_listen == 0) m_n = eff_wait(wait_cfg);
            m_listen++;
            if (m_listen == m_n + 1) ready_next = 1'b1;
        end else begin
            m_listen = 0;
        end
        m_ready = ready_next;
        m_rd    = rd_next;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cyc_ready",     {31'd0, bus.ready}, {31'd0, m_ready});
            check("cyc_rd_data",   {29'd0, rd_data},   {29'd0, m_rd});
            check("cyc_wr_count",  {24'd0, wr_count},  m_count);
            check("cyc_last_addr", {29'd0, last_addr}, {29'd0, m_last});
        end
    end

    // ------------------------------------------------------------------------
    // Master-side write: raise valid, wait (bounded) for ready, pass the
    // handshake edge, optionally hold valid through the GAP edge.
    // lat      = edges between raising valid and seeing ready
    // hi_cnt   = samples with ready=1 during the whole transaction
    // hs_rd    = rd_data just after the handshake edge
    // ------------------------------------------------------------------------
    task automatic do_write(input logic [2:0] a, input logic [2:0] v, input bit hold_extra,
                            output int lat, output int hi_cnt, output logic [2:0] hs_rd);
        bit got;
        lat    = 0;
        hi_cnt = 0;
        got    = 1'b0;
        bus.valid    = 1'b1;
        bus.addr_in  = a;
        bus.value_in = v;
        for (int k = 0; k < 20; k++) begin
            if (bus.ready) begin
                hi_cnt++;
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!got) begin
            timeout("write_ready");
            bus.valid = 1'b0;
            hs_rd = rd_data;
            return;
        end
        @(posedge clk); #1;          // handshake edge
        hs_rd = rd_data;
        if (bus.ready) hi_cnt++;
        if (hold_extra) begin
            @(posedge clk); #1;      // GAP edge: valid must be ignored
            if (bus.ready) hi_cnt++;
        end
        bus.valid = 1'b0;
    endtask

    int         lat, hi_cnt;
    logic [2:0] hs_rd;
    bit         seen;

    initial begin
        rst_n        = 1'b0;
        bus.valid    = 1'b0;
        bus.addr_in  = 3'd0;
        bus.value_in = 3'd0;
        wait_cfg     = 2'd0;
        rd_addr      = 3'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state: every entry reads zero.
        check("rst_ready",    {31'd0, bus.ready}, 0);
        check("rst_wr_count", {24'd0, wr_count}, 0);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            @(posedge clk); #1;
            check("rst_rd_data", {29'd0, rd_data}, 0);
        end

        // wait_cfg=0 write 5<-6, valid held one cycle after the handshake.
        rd_addr = 3'd5;
        do_write(3'd5, 3'd6, 1'b1, lat, hi_cnt, hs_rd);
        check("w0_latency",   lat, 1);
        check("w0_ready_hi",  hi_cnt, 1);
        check("w0_rd_data",   {29'd0, rd_data}, 6);
        check("w0_wr_count",  {24'd0, wr_count}, 1);
        check("w0_last_addr", {29'd0, last_addr}, 5);
        repeat (2) @(posedge clk); #1;
        check("w0_no_gap_write", {24'd0, wr_count}, 1);

        // wait_cfg=3 write 2<-7: ready 3 cycles later when wait states exist.
        wait_cfg = 2'd3;
        rd_addr  = 3'd2;
        do_write(3'd2, 3'd7, 1'b1, lat, hi_cnt, hs_rd);
`ifdef SLAVE_WAIT_EN
        check("w3_latency", lat, 4);
`else
        check("w3_latency", lat, 1);
`endif
        check("w3_ready_hi", hi_cnt, 1);
        repeat (2) @(posedge clk); #1;
        check("w3_rd_data",  {29'd0, rd_data}, 7);
        check("w3_wr_count", {24'd0, wr_count}, 2);

        // Request withdrawn after two edges (aborts in WAIT when enabled).
        bus.valid    = 1'b1;
        bus.addr_in  = 3'd6;
        bus.value_in = 3'd1;
        repeat (2) @(posedge clk);
        #1 bus.valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 wait_cfg = 2'd0;
`ifdef SLAVE_WAIT_EN
        check("abort_wr_count", {24'd0, wr_count}, 2);
`else
        check("abort_wr_count", {24'd0, wr_count}, 3);
`endif

        // Same-edge write and read of address 4: old value first, then new.
        rd_addr = 3'd4;
        repeat (2) @(posedge clk); #1;
        do_write(3'd4, 3'd3, 1'b0, lat, hi_cnt, hs_rd);
        check("same_edge_old", {29'd0, hs_rd}, 0);
        @(posedge clk); #1;
        check("same_edge_new", {29'd0, rd_data}, 3);

        // 256 back-to-back writes: counter saturates at 255.
        for (int i = 0; i < 256; i++) begin
            do_write(3'(i), 3'(i + 1), 1'b1, lat, hi_cnt, hs_rd);
        end
        repeat (2) @(posedge clk); #1;
        check("sat_wr_count",  {24'd0, wr_count}, 255);
        check("sat_last_addr", {29'd0, last_addr}, 7);

        // Reset pulse while in ACK: immediate abort, everything cleared.
        bus.valid    = 1'b1;
        bus.addr_in  = 3'd1;
        bus.value_in = 3'd5;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.ready) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) timeout("rst_ack_ready");
        #1 rst_n = 1'b0;
        #1;
        check("rst_ack_ready",    {31'd0, bus.ready}, 0);
        check("rst_ack_wr_count", {24'd0, wr_count}, 0);
        check("rst_ack_last",     {29'd0, last_addr}, 0);
        bus.valid = 1'b0;
        #1 rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            @(posedge clk); #1;
            check("rst_ack_mem", {29'd0, rd_data}, 0);
        end
        check("rst_ack_wr_count_after", {24'd0, wr_count}, 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_slave_resp
